cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
- Multi-cycle sequencer for the 8-bit accumulator datapath: AC, R, PC, IR, MSB/LSB address registers, zero flag and unified 64K×8 memory.
- Consumes `opcode` and `ACisZero` from the datapath; drives every register enable, memory write strobe and mux select.
- Sits beside the datapath inside the CPU top level.
- Memory read is combinational on the selected address; memory write occurs at the clock edge.

Parameters:
- HALT_OPCODE, 8'hFF, opcode that parks the FSM in HALT.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- run  input  1  leave IDLE and begin fetching
- opcode  input  8  opcode from datapath (IR, or memory when muxOpcode=1)
- ACisZero  input  1  zero-flag register value
- writeEnableAC  output  1  load AC
- writeEnableR  output  1  load R from AC
- writeEnableMem  output  1  write AC to memory
- PCEnable  output  1  load PC
- instructionRegisterEnable  output  1  load IR
- MSBaddressEnable  output  1  load address high byte
- LSBaddressEnable  output  1  load address low byte
- zeroEnable  output  1  load zero flag
- muxOpcode  output  1  0=IR, 1=memory data to opcode
- muxSelectPC  output  1  0=PC+1, 1={MSB,LSB}
- muxSelectAddress  output  1  0=PC, 1={MSB,LSB}
- muxSelectALUtoAC  output  1  0=ALU, 1=MEM/R path
- muxSelectMEM_or_R_toAC  output  1  0=R, 1=memory
- halted  output  1  FSM in HALT
- illegal  output  1  one-cycle pulse on undefined opcode
- instrDone  output  1  one-cycle pulse in the final state of each instruction

Behaviour:
- Reset (reset=0, async): state=IDLE, all outputs 0. Reset mid-instruction aborts immediately; no partial writes occur after assertion.
- All outputs are combinational from state, registered opcode and ACisZero. Any output not listed for a state is 0.
- IDLE: all outputs 0; run=1 → FETCH.
- FETCH: muxSelectAddress=0, instructionRegisterEnable=1, PCEnable=1, muxSelectPC=0, muxOpcode=1 → DECODE.
- DECODE: opcode from IR (muxOpcode=0).
  - Γ-opcodes 01,02,05,06,07 → ADDR_HI.
  - HALT_OPCODE → HALT.
  - Otherwise → EXEC.
- ADDR_HI: muxSelectAddress=0, MSBaddressEnable=1, PCEnable=1 (PC+1) → ADDR_LO.
- ADDR_LO: same with LSBaddressEnable=1 → EXEC.
- EXEC (instrDone=1, → FETCH):
  - 00 NOP: nothing.
  - 01 LDAC: muxSelectAddress=1, muxSelectMEM_or_R_toAC=1, muxSelectALUtoAC=1, writeEnableAC=1, zeroEnable=1.
  - 02 STAC: muxSelectAddress=1, writeEnableMem=1.
  - 03 MVAC: writeEnableR=1.
  - 04 MOVR: muxSelectMEM_or_R_toAC=0, muxSelectALUtoAC=1, writeEnableAC=1, zeroEnable=1.
  - 05 JUMP: muxSelectPC=1, PCEnable=1.
  - 06 JMPZ: as JUMP only if ACisZero=1; otherwise no PC load (PC already past operand).
  - 07 JPNZ: as JUMP only if ACisZero=0.
  - 08–0F ALU ops: muxSelectALUtoAC=0, writeEnableAC=1, zeroEnable=1. ALU function comes from opcode[2:0] inside the datapath.
  - 10–FE except HALT_OPCODE: treated as NOP, illegal=1 for that EXEC cycle.
- HALT: halted=1, all enables 0, held until reset. run is ignored.
- Latency:
  - Non-Γ instruction: 3 cycles (FETCH, DECODE, EXEC).
  - Γ instruction: 5 cycles.
  - PC advances by 1 per opcode/operand byte fetched.
- At most one of writeEnableAC/writeEnableMem/PCEnable-with-muxSelectPC=1 is active in any cycle.
- run deasserting outside IDLE has no effect.

Test Plan:
- Reset low mid-ADDR_HI → all outputs 0 same cycle. Release with run=1 → FETCH next edge, PC=0000.
- Program 01 12 34 (LDAC 1234h), mem[1234h]=00 → 5 cycles. EXEC asserts writeEnableAC, zeroEnable, muxSelectAddress=1. AC=00, ACisZero=1, PC=0003.
- STAC 02 00 80 with AC=5A → single writeEnableMem pulse. mem[0080h]=5A, PC=0003.
- JMPZ 06 00 40 with ACisZero=0 → PC=0003. With ACisZero=1 → PC=0040.
- MVAC then ALU op 08 with AC=03, R=03 → writeEnableR in EXEC of MVAC. ALU EXEC has muxSelectALUtoAC=0, writeEnableAC=1. Each instruction takes 3 cycles.
- Opcode 3C → illegal pulses once, PC advances by 1. Opcode FF → halted=1 and stays there 20+ cycles with run toggling.

Source files
------------

// File: rtl/cpu_control_if.sv
// cpu_control_if: control unit <-> datapath bundle.
// Status flows into the sequencer; enables and mux selects flow out.
interface cpu_control_if;
    logic       run;
    logic [7:0] opcode;
    logic       ACisZero;
    logic       writeEnableAC;
    logic       writeEnableR;
    logic       writeEnableMem;
    logic       PCEnable;
    logic       instructionRegisterEnable;
    logic       MSBaddressEnable;
    logic       LSBaddressEnable;
    logic       zeroEnable;
    logic       muxOpcode;
    logic       muxSelectPC;
    logic       muxSelectAddress;
    logic       muxSelectALUtoAC;
    logic       muxSelectMEM_or_R_toAC;
    logic       halted;
    logic       illegal;
    logic       instrDone;

    modport master (
        input  run, opcode, ACisZero,
        output writeEnableAC, writeEnableR, writeEnableMem, PCEnable,
        output instructionRegisterEnable, MSBaddressEnable,
        output LSBaddressEnable, zeroEnable, muxOpcode, muxSelectPC,
        output muxSelectAddress, muxSelectALUtoAC,
        output muxSelectMEM_or_R_toAC, halted, illegal, instrDone
    );

    modport slave (
        output run, opcode, ACisZero,
        input  writeEnableAC, writeEnableR, writeEnableMem, PCEnable,
        input  instructionRegisterEnable, MSBaddressEnable,
        input  LSBaddressEnable, zeroEnable, muxOpcode, muxSelectPC,
        input  muxSelectAddress, muxSelectALUtoAC,
        input  muxSelectMEM_or_R_toAC, halted, illegal, instrDone
    );
endinterface

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle sequencer for the 8-bit accumulator CPU.
// Outputs are decoded from state, the latched opcode and the zero flag.
module cpu_control_unit #(
    parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
    input logic           clk,
    input logic           reset,
    cpu_control_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_EXEC,
        S_HALT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] op_q, op_d;

    // Opcodes that carry a two-byte address operand.
    function automatic logic is_gamma(input logic [7:0] op);
        return (op == 8'h01) || (op == 8'h02) ||
               (op >= 8'h05 && op <= 8'h07);
    endfunction

    // State register and opcode latch; reset aborts any instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state selection and every control strobe.
    always_comb begin
        state_d                      = state_q;
        op_d                         = op_q;
        bus.writeEnableAC            = 1'b0;
        bus.writeEnableR             = 1'b0;
        bus.writeEnableMem           = 1'b0;
        bus.PCEnable                 = 1'b0;
        bus.instructionRegisterEnable = 1'b0;
        bus.MSBaddressEnable         = 1'b0;
        bus.LSBaddressEnable         = 1'b0;
        bus.zeroEnable               = 1'b0;
        bus.muxOpcode                = 1'b0;
        bus.muxSelectPC              = 1'b0;
        bus.muxSelectAddress         = 1'b0;
        bus.muxSelectALUtoAC         = 1'b0;
        bus.muxSelectMEM_or_R_toAC   = 1'b0;
        bus.halted                   = 1'b0;
        bus.illegal                  = 1'b0;
        bus.instrDone                = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_FETCH;
            end
            S_FETCH: begin
                bus.instructionRegisterEnable = 1'b1;
                bus.PCEnable                  = 1'b1;
                bus.muxOpcode                 = 1'b1;
                state_d                       = S_DECODE;
            end
            S_DECODE: begin
                op_d = bus.opcode;
                if (is_gamma(bus.opcode))
                    state_d = S_ADDR_HI;
                else if (bus.opcode == HALT_OPCODE)
                    state_d = S_HALT;
                else
                    state_d = S_EXEC;
            end
            S_ADDR_HI: begin
                bus.MSBaddressEnable = 1'b1;
                bus.PCEnable         = 1'b1;
                state_d              = S_ADDR_LO;
            end
            S_ADDR_LO: begin
                bus.LSBaddressEnable = 1'b1;
                bus.PCEnable         = 1'b1;
                state_d              = S_EXEC;
            end
            S_EXEC: begin
                bus.instrDone = 1'b1;
                state_d       = S_FETCH;
                unique case (1'b1)
                    op_q == 8'h00: begin
                    end
                    op_q == 8'h01: begin
                        bus.muxSelectAddress       = 1'b1;
                        bus.muxSelectMEM_or_R_toAC = 1'b1;
                        bus.muxSelectALUtoAC       = 1'b1;
                        bus.writeEnableAC          = 1'b1;
                        bus.zeroEnable             = 1'b1;
                    end
                    op_q == 8'h02: begin
                        bus.muxSelectAddress = 1'b1;
                        bus.writeEnableMem   = 1'b1;
                    end
                    op_q == 8'h03: begin
                        bus.writeEnableR = 1'b1;
                    end
                    op_q == 8'h04: begin
                        bus.muxSelectALUtoAC = 1'b1;
                        bus.writeEnableAC    = 1'b1;
                        bus.zeroEnable       = 1'b1;
                    end
                    op_q == 8'h05: begin
                        bus.muxSelectPC = 1'b1;
                        bus.PCEnable    = 1'b1;
                    end
                    op_q == 8'h06: begin
                        bus.muxSelectPC = bus.ACisZero;
                        bus.PCEnable    = bus.ACisZero;
                    end
                    op_q == 8'h07: begin
                        bus.muxSelectPC = !bus.ACisZero;
                        bus.PCEnable    = !bus.ACisZero;
                    end
                    op_q[7:3] == 5'b00001: begin
                        bus.writeEnableAC = 1'b1;
                        bus.zeroEnable    = 1'b1;
                    end
                    default: begin
                        bus.illegal = 1'b1;
                    end
                endcase
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: datapath model around the sequencer.
// Expected per-instruction results are queued and matched on instrDone.
module tb_cpu_control_unit;
    localparam int B_WAC = 13, B_WR = 12, B_WMEM = 11, B_PCE = 10;
    localparam int B_MPC = 9, B_MADR = 8, B_MALU = 7, B_MMR = 6;
    localparam int B_ZE = 5, B_IRE = 4, B_ILL = 0;
    localparam logic [13:0] ONE = 14'd1;
    localparam logic [13:0] C_NOP = '0;
    localparam logic [13:0] C_LDAC = (ONE << B_WAC) | (ONE << B_MADR) |
        (ONE << B_MALU) | (ONE << B_MMR) | (ONE << B_ZE);
    localparam logic [13:0] C_STAC = (ONE << B_WMEM) | (ONE << B_MADR);
    localparam logic [13:0] C_MVAC = (ONE << B_WR);
    localparam logic [13:0] C_MOVR = (ONE << B_WAC) | (ONE << B_MALU) |
        (ONE << B_ZE);
    localparam logic [13:0] C_ALU = (ONE << B_WAC) | (ONE << B_ZE);
    localparam logic [13:0] C_JMP = (ONE << B_PCE) | (ONE << B_MPC);
    localparam logic [13:0] C_ILL = (ONE << B_ILL);

    typedef struct {
        int          cyc;
        logic [13:0] ctl;
    } obs_t;
    typedef struct {
        int          cyc;
        logic [13:0] ctl;
        logic [15:0] pc;
        logic [7:0]  ac;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    cpu_control_if bus ();

    cpu_control_unit #(.HALT_OPCODE(8'hFF)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Datapath model
    logic [7:0]  mem [0:65535];
    logic [15:0] pc;
    logic [7:0]  ir, msb, lsb, ac, r, alu;
    logic        zf;
    logic        tb_we = 1'b0;
    logic [15:0] tb_wa = '0;
    logic [7:0]  tb_wd = '0;
    wire  [15:0] addr = bus.muxSelectAddress ? {msb, lsb} : pc;
    wire  [7:0]  md = mem[addr];
    wire  [7:0]  ac_in = bus.muxSelectALUtoAC ?
                 (bus.muxSelectMEM_or_R_toAC ? md : r) : alu;
    assign bus.opcode   = bus.muxOpcode ? md : ir;
    assign bus.ACisZero = zf;

    always_comb begin
        alu = ac;
        case (ir[2:0])
            3'd0: alu = ac + r;
            3'd1: alu = ac - r;
            3'd2: alu = ac & r;
            3'd3: alu = ac | r;
            3'd4: alu = ac ^ r;
            3'd5: alu = ~ac;
            3'd6: alu = ac + 8'd1;
            default: alu = ac;
        endcase
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0; ir <= '0; msb <= '0; lsb <= '0;
            ac <= '0; r <= '0; zf <= 1'b0;
        end else begin
            if (bus.PCEnable)
                pc <= bus.muxSelectPC ? {msb, lsb} : pc + 16'd1;
            if (bus.instructionRegisterEnable) ir <= md;
            if (bus.MSBaddressEnable) msb <= md;
            if (bus.LSBaddressEnable) lsb <= md;
            if (bus.writeEnableAC) ac <= ac_in;
            if (bus.zeroEnable) zf <= (ac_in == 8'h00);
            if (bus.writeEnableR) r <= ac;
        end
    end

    always @(posedge clk) begin
        if (tb_we) mem[tb_wa] <= tb_wd;
        if (bus.writeEnableMem) mem[addr] <= ac;
    end

    // Output monitor
    wire [13:0] ctl_w = {bus.writeEnableAC, bus.writeEnableR,
        bus.writeEnableMem, bus.PCEnable, bus.muxSelectPC,
        bus.muxSelectAddress, bus.muxSelectALUtoAC,
        bus.muxSelectMEM_or_R_toAC, bus.zeroEnable,
        bus.instructionRegisterEnable, bus.MSBaddressEnable,
        bus.LSBaddressEnable, bus.muxOpcode, bus.illegal};
    obs_t obs_q[$];
    exp_t exp_q[$];
    int   cnt = 0;
    int   wem_total = 0;
    int   excl_bad = 0;
    int   tests = 0;
    int   failed = 0;

    always @(negedge clk) begin
        if (!reset) begin
            cnt = 0;
        end else begin
            if (bus.instructionRegisterEnable) cnt = 1;
            else if (cnt != 0) cnt++;
            if (bus.writeEnableMem) wem_total++;
            if (int'(bus.writeEnableAC) + int'(bus.writeEnableMem) +
                int'(bus.PCEnable && bus.muxSelectPC) > 1)
                excl_bad++;
            if (bus.instrDone) begin
                obs_q.push_back(obs_t'{cyc: cnt, ctl: ctl_w});
                cnt = 0;
            end
        end
    end

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        tb_wa = a; tb_wd = d; tb_we = 1'b1;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic begin_prog();
        bus.run = 1'b0;
        reset = 1'b0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic go();
        @(negedge clk);
        reset = 1'b1;
        bus.run = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e; obs_t o; bit got;
        begin_prog();
        poke(16'h0000, 8'h01); poke(16'h0001, 8'h12);
        poke(16'h0002, 8'h34); poke(16'h0003, 8'hFF);
        poke(16'h1234, 8'h00);
        @(negedge clk); #1;
        tests++;
        if ({ctl_w, bus.halted, bus.instrDone} !== 16'h0) begin
            failed++;
            $display("FAIL reset_idle: got %h required 0",
                {ctl_w, bus.halted, bus.instrDone});
        end
        go();
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk); #1;
            got = bus.MSBaddressEnable;
        end
        tests++;
        if (!got) begin
            failed++;
            $display("FAIL reach_addr_hi: got 0 required 1");
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({ctl_w, bus.halted, bus.instrDone} !== 16'h0) begin
            failed++;
            $display("FAIL reset_async: got %h required 0",
                {ctl_w, bus.halted, bus.instrDone});
        end
        obs_q.delete();
        exp_q.push_back(exp_t'{5, C_LDAC, 16'h0003, 8'h00, 1'b1});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        tests++;
        if ({bus.instructionRegisterEnable, pc} !== {1'b1, 16'h0000}) begin
            failed++;
            $display("FAIL fetch_after_reset: got ire=%b pc=%h required 1 0000",
                bus.instructionRegisterEnable, pc);
        end
        got = 0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk); #1;
            got = obs_q.size() != 0;
        end
        tests++;
        if (!got) begin
            failed++;
            $display("FAIL reset_ldac_done: got none required instrDone");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            tests++;
            if (o.cyc !== e.cyc) begin
                failed++;
                $display("FAIL reset_ldac_cycles: got %0d required %0d", o.cyc, e.cyc);
            end
            tests++;
            if (o.ctl !== e.ctl) begin
                failed++;
                $display("FAIL reset_ldac_ctl: got %b required %b", o.ctl, e.ctl);
            end
            @(negedge clk); #1;
            tests++;
            if ({pc, ac, zf} !== {e.pc, e.ac, e.z}) begin
                failed++;
                $display("FAIL reset_ldac_state: got pc=%h ac=%h z=%b required %h %h %b",
                    pc, ac, zf, e.pc, e.ac, e.z);
            end
        end
    endtask

    task automatic test_ldac();
        exp_t e; obs_t o; bit got;
        begin_prog();
        poke(16'h0000, 8'h01); poke(16'h0001, 8'h12); poke(16'h0002, 8'h35);
        poke(16'h0003, 8'h01); poke(16'h0004, 8'h12); poke(16'h0005, 8'h34);
        poke(16'h0006, 8'hFF);
        poke(16'h1235, 8'hA5); poke(16'h1234, 8'h00);
        exp_q.push_back(exp_t'{5, C_LDAC, 16'h0003, 8'hA5, 1'b0});
        exp_q.push_back(exp_t'{5, C_LDAC, 16'h0006, 8'h00, 1'b1});
        go();
        for (int k = 0; k < 2; k++) begin
            got = 0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk); #1;
                got = obs_q.size() != 0;
            end
            tests++;
            if (!got) begin
                failed++;
                $display("FAIL ldac_done k=%0d: got none required instrDone", k);
                break;
            end
            o = obs_q.pop_front(); e = exp_q.pop_front();
            tests++;
            if (o.cyc !== e.cyc) begin
                failed++;
                $display("FAIL ldac_cycles k=%0d: got %0d required %0d", k, o.cyc, e.cyc);
            end
            tests++;
            if (o.ctl !== e.ctl) begin
                failed++;
                $display("FAIL ldac_ctl k=%0d: got %b required %b", k, o.ctl, e.ctl);
            end
            @(negedge clk); #1;
            tests++;
            if ({pc, ac, zf} !== {e.pc, e.ac, e.z}) begin
                failed++;
                $display("FAIL ldac_state k=%0d: got pc=%h ac=%h z=%b required %h %h %b",
                    k, pc, ac, zf, e.pc, e.ac, e.z);
            end
        end
    endtask

    task automatic test_stac();
        exp_t e; obs_t o; bit got; int w0;
        begin_prog();
        poke(16'h0000, 8'h01); poke(16'h0001, 8'h00); poke(16'h0002, 8'h90);
        poke(16'h0003, 8'h02); poke(16'h0004, 8'h00); poke(16'h0005, 8'h80);
        poke(16'h0006, 8'hFF);
        poke(16'h0090, 8'h5A); poke(16'h0080, 8'h00);
        w0 = wem_total;
        exp_q.push_back(exp_t'{5, C_LDAC, 16'h0003, 8'h5A, 1'b0});
        exp_q.push_back(exp_t'{5, C_STAC, 16'h0006, 8'h5A, 1'b0});
        go();
        for (int k = 0; k < 2; k++) begin
            got = 0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk); #1;
                got = obs_q.size() != 0;
            end
            tests++;
            if (!got) begin
                failed++;
                $display("FAIL stac_done k=%0d: got none required instrDone", k);
                break;
            end
            o = obs_q.pop_front(); e = exp_q.pop_front();
            tests++;
            if (o.cyc !== e.cyc) begin
                failed++;
                $display("FAIL stac_cycles k=%0d: got %0d required %0d", k, o.cyc, e.cyc);
            end
            tests++;
            if (o.ctl !== e.ctl) begin
                failed++;
                $display("FAIL stac_ctl k=%0d: got %b required %b", k, o.ctl, e.ctl);
            end
            @(negedge clk); #1;
            tests++;
            if ({pc, ac, zf} !== {e.pc, e.ac, e.z}) begin
                failed++;
                $display("FAIL stac_state k=%0d: got pc=%h ac=%h z=%b required %h %h %b",
                    k, pc, ac, zf, e.pc, e.ac, e.z);
            end
        end
        repeat (4) @(negedge clk);
        #1;
        tests++;
        if (mem[16'h0080] !== 8'h5A) begin
            failed++;
            $display("FAIL stac_mem: got %h required 5a", mem[16'h0080]);
        end
        tests++;
        if (wem_total - w0 !== 1) begin
            failed++;
            $display("FAIL stac_pulses: got %0d required 1", wem_total - w0);
        end
    endtask

    task automatic test_branch();
        exp_t e; obs_t o; bit got;
        begin_prog();
        poke(16'h0000, 8'h01); poke(16'h0001, 8'h00); poke(16'h0002, 8'h90);
        poke(16'h0003, 8'h06); poke(16'h0004, 8'h00); poke(16'h0005, 8'h40);
        poke(16'h0006, 8'h01); poke(16'h0007, 8'h00); poke(16'h0008, 8'h91);
        poke(16'h0009, 8'h06); poke(16'h000A, 8'h00); poke(16'h000B, 8'h40);
        poke(16'h0040, 8'h07); poke(16'h0041, 8'h00); poke(16'h0042, 8'h50);
        poke(16'h0043, 8'hFF);
        poke(16'h0090, 8'h5A); poke(16'h0091, 8'h00);
        exp_q.push_back(exp_t'{5, C_LDAC, 16'h0003, 8'h5A, 1'b0});
        exp_q.push_back(exp_t'{5, C_NOP,  16'h0006, 8'h5A, 1'b0});
        exp_q.push_back(exp_t'{5, C_LDAC, 16'h0009, 8'h00, 1'b1});
        exp_q.push_back(exp_t'{5, C_JMP,  16'h0040, 8'h00, 1'b1});
        exp_q.push_back(exp_t'{5, C_NOP,  16'h0043, 8'h00, 1'b1});
        go();
        for (int k = 0; k < 5; k++) begin
            got = 0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk); #1;
                got = obs_q.size() != 0;
            end
            tests++;
            if (!got) begin
                failed++;
                $display("FAIL branch_done k=%0d: got none required instrDone", k);
                break;
            end
            o = obs_q.pop_front(); e = exp_q.pop_front();
            tests++;
            if (o.cyc !== e.cyc) begin
                failed++;
                $display("FAIL branch_cycles k=%0d: got %0d required %0d", k, o.cyc, e.cyc);
            end
            tests++;
            if (o.ctl !== e.ctl) begin
                failed++;
                $display("FAIL branch_ctl k=%0d: got %b required %b", k, o.ctl, e.ctl);
            end
            @(negedge clk); #1;
            tests++;
            if ({pc, ac, zf} !== {e.pc, e.ac, e.z}) begin
                failed++;
                $display("FAIL branch_state k=%0d: got pc=%h ac=%h z=%b required %h %h %b",
                    k, pc, ac, zf, e.pc, e.ac, e.z);
            end
        end
    endtask

    task automatic test_alu();
        exp_t e; obs_t o; bit got;
        begin_prog();
        poke(16'h0000, 8'h01); poke(16'h0001, 8'h00); poke(16'h0002, 8'h92);
        poke(16'h0003, 8'h03); poke(16'h0004, 8'h08); poke(16'h0005, 8'h04);
        poke(16'h0006, 8'hFF);
        poke(16'h0092, 8'h03);
        exp_q.push_back(exp_t'{5, C_LDAC, 16'h0003, 8'h03, 1'b0});
        exp_q.push_back(exp_t'{3, C_MVAC, 16'h0004, 8'h03, 1'b0});
        exp_q.push_back(exp_t'{3, C_ALU,  16'h0005, 8'h06, 1'b0});
        exp_q.push_back(exp_t'{3, C_MOVR, 16'h0006, 8'h03, 1'b0});
        go();
        for (int k = 0; k < 4; k++) begin
            got = 0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk); #1;
                got = obs_q.size() != 0;
            end
            tests++;
            if (!got) begin
                failed++;
                $display("FAIL alu_done k=%0d: got none required instrDone", k);
                break;
            end
            o = obs_q.pop_front(); e = exp_q.pop_front();
            tests++;
            if (o.cyc !== e.cyc) begin
                failed++;
                $display("FAIL alu_cycles k=%0d: got %0d required %0d", k, o.cyc, e.cyc);
            end
            tests++;
            if (o.ctl !== e.ctl) begin
                failed++;
                $display("FAIL alu_ctl k=%0d: got %b required %b", k, o.ctl, e.ctl);
            end
            @(negedge clk); #1;
            tests++;
            if ({pc, ac, zf} !== {e.pc, e.ac, e.z}) begin
                failed++;
                $display("FAIL alu_state k=%0d: got pc=%h ac=%h z=%b required %h %h %b",
                    k, pc, ac, zf, e.pc, e.ac, e.z);
            end
        end
    endtask

    task automatic test_illegal_halt();
        exp_t e; obs_t o; bit got; int bad;
        begin_prog();
        poke(16'h0000, 8'h3C); poke(16'h0001, 8'h00); poke(16'h0002, 8'hFF);
        exp_q.push_back(exp_t'{3, C_ILL, 16'h0001, 8'h00, 1'b0});
        exp_q.push_back(exp_t'{3, C_NOP, 16'h0002, 8'h00, 1'b0});
        go();
        for (int k = 0; k < 2; k++) begin
            got = 0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk); #1;
                got = obs_q.size() != 0;
            end
            tests++;
            if (!got) begin
                failed++;
                $display("FAIL ill_done k=%0d: got none required instrDone", k);
                break;
            end
            o = obs_q.pop_front(); e = exp_q.pop_front();
            tests++;
            if (o.cyc !== e.cyc) begin
                failed++;
                $display("FAIL ill_cycles k=%0d: got %0d required %0d", k, o.cyc, e.cyc);
            end
            tests++;
            if (o.ctl !== e.ctl) begin
                failed++;
                $display("FAIL ill_ctl k=%0d: got %b required %b", k, o.ctl, e.ctl);
            end
            @(negedge clk); #1;
            tests++;
            if ({pc, ac, zf} !== {e.pc, e.ac, e.z}) begin
                failed++;
                $display("FAIL ill_state k=%0d: got pc=%h ac=%h z=%b required %h %h %b",
                    k, pc, ac, zf, e.pc, e.ac, e.z);
            end
        end
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk); #1;
            got = bus.halted;
        end
        tests++;
        if (!got) begin
            failed++;
            $display("FAIL halt_reach: got 0 required 1");
        end
        bad = 0;
        for (int t = 0; t < 24; t++) begin
            bus.run = t[0];
            @(negedge clk); #1;
            if (bus.halted !== 1'b1 || ctl_w !== 14'h0 ||
                bus.instrDone !== 1'b0 || obs_q.size() != 0)
                bad++;
        end
        tests++;
        if (bad != 0) begin
            failed++;
            $display("FAIL halt_hold: got %0d bad cycles required 0", bad);
        end
        tests++;
        if (pc !== 16'h0003) begin
            failed++;
            $display("FAIL halt_pc: got %h required 0003", pc);
        end
    endtask

    initial begin
        bus.run = 1'b0;
        test_reset();
        test_ldac();
        test_stac();
        test_branch();
        test_alu();
        test_illegal_halt();
        tests++;
        if (excl_bad != 0) begin
            failed++;
            $display("FAIL exclusive_writes: got %0d bad cycles required 0", excl_bad);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
